cr_kme_drng_key_assembler: RTL and testbench

CR_KME_DRNG_KEY_ASSEMBLER -- requirements
Module: cr_kme_drng_key_assembler

---
 rtl/cr_kme_drng_key_assembler.sv | 150 +++++++++++++++
 tb/tb_cr_kme_drng_key_assembler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cr_kme_drng_key_assembler.sv
`default_nettype none
// ============================================================================
// Module   : cr_kme_drng_key_assembler
// Brief    : Pops two 128-bit DRNG words and presents them as one 256-bit key
//            (first word in [255:128], second in [127:0]). A seed expiry in
//            mid-assembly drops the half-built key. An optional repetition
//            health test rejects a word equal to the previous accepted word;
//            it is compiled in by defining CR_KME_DRNG_HEALTH_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cr_kme_drng_key_assembler #(
    parameter int FAIL_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  drng_valid,
    input  logic [127:0]          drng_256_out,
    input  logic                  seed_expired,
    output logic                  drng_ack,
    input  logic                  flush,
    output logic                  key_valid,
    output logic [255:0]          key_out,
    input  logic                  key_ack,
    output logic                  health_fail,
    output logic [FAIL_CNT_W-1:0] fail_cnt
);

    typedef enum logic [1:0] {
        FILL_HI = 2'd0,
        FILL_LO = 2'd1,
        KEY_RDY = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_key_valid;
    logic [255:0]   r_key_out;
    logic [127:0]   r_prev_word;
    logic           r_prev_vld;

    logic           w_ack;
    logic           w_reject;
    logic           w_take;

    // Pop the FIFO head whenever a word can be used; held off during reset,
    // while a key is pending, on flush and on a mid-assembly seed expiry.
    assign w_ack = rst_n & drng_valid & (r_state != KEY_RDY) & ~flush
                 & ~((r_state == FILL_LO) & seed_expired);

    // An accepted word goes into the key unless the health test rejects it.
    assign w_take = w_ack & ~w_reject;

    // Key assembly state machine with registered key outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FILL_HI;
            r_key_valid <= 1'b0;
            r_key_out   <= '0;
        end else if (flush) begin
            // key_out is intentionally left as-is; only the handshake drops.
            r_state     <= FILL_HI;
            r_key_valid <= 1'b0;
        end else begin
            case (r_state)
                FILL_HI: begin
                    if (w_take) begin
                        r_key_out[255:128] <= drng_256_out;
                        r_state            <= FILL_LO;
                    end
                end
                FILL_LO: begin
                    if (seed_expired) begin
                        // A key must never straddle a reseed.
                        r_state <= FILL_HI;
                    end else if (w_take) begin
                        r_key_out[127:0] <= drng_256_out;
                        r_state          <= KEY_RDY;
                        r_key_valid      <= 1'b1;
                    end
                end
                KEY_RDY: begin
                    if (key_ack) begin
                        r_state     <= FILL_HI;
                        r_key_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= FILL_HI;
                    r_key_valid <= 1'b0;
                end
            endcase
        end
    end

    // Previous-word history: every popped word is recorded; history is
    // invalidated by flush or by a seed-expiry discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_word <= '0;
            r_prev_vld  <= 1'b0;
        end else if (flush) begin
            r_prev_vld  <= 1'b0;
        end else if ((r_state == FILL_LO) && seed_expired) begin
            r_prev_vld  <= 1'b0;
        end else if (w_ack) begin
            r_prev_word <= drng_256_out;
            r_prev_vld  <= 1'b1;
        end
    end

`ifdef CR_KME_DRNG_HEALTH_CHECK_EN
    logic                  r_health_fail;
    logic [FAIL_CNT_W-1:0] r_fail_cnt;

    // Repetition test: a word identical to the last popped word is rejected.
    assign w_reject = r_prev_vld & (drng_256_out == r_prev_word);

    // Sticky failure flag and saturating rejected-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_health_fail <= 1'b0;
            r_fail_cnt    <= '0;
        end else if (flush) begin
            r_health_fail <= 1'b0;
            r_fail_cnt    <= '0;
        end else if (w_ack && w_reject) begin
            r_health_fail <= 1'b1;
            if (r_fail_cnt != {FAIL_CNT_W{1'b1}}) begin
                r_fail_cnt <= r_fail_cnt + {{(FAIL_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign health_fail = r_health_fail;
    assign fail_cnt    = r_fail_cnt;
`else
    logic w_unused_prev;

    assign w_reject    = 1'b0;
    assign health_fail = 1'b0;
    assign fail_cnt    = '0;
    // History is kept but has no consumer when the health test is absent.
    assign w_unused_prev = ^{r_prev_word, r_prev_vld};
`endif

    assign drng_ack  = w_ack;
    assign key_valid = r_key_valid;
    assign key_out   = r_key_out;

endmodule
`default_nettype wire

// File: tb/tb_cr_kme_drng_key_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cr_kme_drng_key_assembler
// Brief    : Self-checking bench for the DRNG key assembler: a table of
//            per-cycle vectors plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cr_kme_drng_key_assembler;

    localparam int FAIL_CNT_W = 8;
    localparam logic [127:0] A = {32{4'h1}};
    localparam logic [127:0] B = {32{4'h2}};
    localparam logic [127:0] C = {32{4'h3}};
    localparam logic [127:0] D = {32{4'h4}};
    localparam logic [127:0] E = {32{4'h5}};
    localparam int NV = 20;

    logic                  clk;
    logic                  rst_n;
    logic                  drng_valid;
    logic [127:0]          drng_256_out;
    logic                  seed_expired;
    logic                  drng_ack;
    logic                  flush;
    logic                  key_valid;
    logic [255:0]          key_out;
    logic                  key_ack;
    logic                  health_fail;
    logic [FAIL_CNT_W-1:0] fail_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         v;
        logic [127:0] w;
        logic         se;
        logic         fl;
        logic         ka;
        logic         e_ack;
        logic         e_kv;
        logic         ck;
        logic [255:0] e_key;
    } vec_t;

    vec_t tbl [NV];

    cr_kme_drng_key_assembler #(.FAIL_CNT_W(FAIL_CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .drng_valid   (drng_valid),
        .drng_256_out (drng_256_out),
        .seed_expired (seed_expired),
        .drng_ack     (drng_ack),
        .flush        (flush),
        .key_valid    (key_valid),
        .key_out      (key_out),
        .key_ack      (key_ack),
        .health_fail  (health_fail),
        .fail_cnt     (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge; outputs settle by +1.
    task automatic apply(input logic v, input logic [127:0] w, input logic se,
                         input logic fl, input logic ka);
        @(negedge clk);
        drng_valid   = v;
        drng_256_out = w;
        seed_expired = se;
        flush        = fl;
        key_ack      = ka;
        #1;
    endtask

    initial begin
        //             v     word  se    fl    ka    ack   kv    ck    key
        tbl[0]  = '{1'b1, A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 256'h0};
        tbl[1]  = '{1'b1, B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 256'h0};
        tbl[2]  = '{1'b1, C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {A, B}};
        tbl[3]  = '{1'b0, C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, {A, B}};
        tbl[4]  = '{1'b0, C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {A, B}};
        tbl[5]  = '{1'b1, A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 256'h0};
        tbl[6]  = '{1'b1, C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 256'h0};
        tbl[7]  = '{1'b1, C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 256'h0};
        tbl[8]  = '{1'b1, D, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 256'h0};
        tbl[9]  = '{1'b0, E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {C, D}};
        tbl[10] = '{1'b1, A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, {C, D}};
        tbl[11] = '{1'b1, A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, {C, D}};
        tbl[12] = '{1'b1, B, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, {A, D}};
        tbl[13] = '{1'b0, B, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {A, D}};
        tbl[14] = '{1'b1, B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, {A, D}};
        tbl[15] = '{1'b1, C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, {B, D}};
        tbl[16] = '{1'b1, C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, {B, D}};
        tbl[17] = '{1'b1, D, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, {C, D}};
        tbl[18] = '{1'b1, E, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, {C, D}};
        tbl[19] = '{1'b0, E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {C, D}};

        // Reset with a word already waiting: nothing may be popped.
        rst_n        = 1'b0;
        drng_valid   = 1'b1;
        drng_256_out = A;
        seed_expired = 1'b0;
        flush        = 1'b0;
        key_ack      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ack",     {255'b0, drng_ack},    256'h0);
        chk("rst_kv",      {255'b0, key_valid},   256'h0);
        chk("rst_key",     key_out,               256'h0);
        chk("rst_hf",      {255'b0, health_fail}, 256'h0);
        chk("rst_fcnt",    {248'b0, fail_cnt},    256'h0);
        drng_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven per-cycle vectors.
        for (int i = 0; i < NV; i++) begin
            apply(tbl[i].v, tbl[i].w, tbl[i].se, tbl[i].fl, tbl[i].ka);
            chk($sformatf("vec%0d_ack", i), {255'b0, drng_ack},  {255'b0, tbl[i].e_ack});
            chk($sformatf("vec%0d_kv", i),  {255'b0, key_valid}, {255'b0, tbl[i].e_kv});
            if (tbl[i].ck) begin
                chk($sformatf("vec%0d_key", i), key_out, tbl[i].e_key);
            end
            chk($sformatf("vec%0d_hf", i),  {255'b0, health_fail}, 256'h0);
            chk($sformatf("vec%0d_fc", i),  {248'b0, fail_cnt},    256'h0);
        end

        // Pending key held for 10 cycles with the DRNG offering data.
        apply(1'b1, A, 1'b0, 1'b0, 1'b0);
        apply(1'b1, B, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, C, 1'b0, 1'b0, 1'b0);
            chk($sformatf("hold%0d_ack", i), {255'b0, drng_ack},  256'h0);
            chk($sformatf("hold%0d_kv", i),  {255'b0, key_valid}, 256'h1);
            chk($sformatf("hold%0d_key", i), key_out, {A, B});
        end
        apply(1'b1, C, 1'b0, 1'b0, 1'b1);
        chk("hold_ack_cyc", {255'b0, drng_ack}, 256'h0);
        apply(1'b1, C, 1'b0, 1'b0, 1'b0);
        chk("post_ack_accept", {255'b0, drng_ack},  256'h1);
        chk("post_ack_kv",     {255'b0, key_valid}, 256'h0);
        apply(1'b1, D, 1'b0, 1'b0, 1'b0);
        chk("post_ack_lo", {255'b0, drng_ack}, 256'h1);

        // Asynchronous reset in mid-cycle while a key is pending.
        apply(1'b1, E, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_kv",  {255'b0, key_valid}, 256'h1);
        chk("pre_rst_key", key_out, {C, D});
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_kv",  {255'b0, key_valid}, 256'h0);
        chk("mid_rst_key", key_out,             256'h0);
        chk("mid_rst_ack", {255'b0, drng_ack},  256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_rst_ack", {255'b0, drng_ack}, 256'h1);
        apply(1'b1, B, 1'b0, 1'b0, 1'b0);
        chk("rel_lo_ack", {255'b0, drng_ack},  256'h1);
        apply(1'b0, B, 1'b0, 1'b0, 1'b0);
        chk("rel_kv",     {255'b0, key_valid}, 256'h1);
        chk("rel_key",    key_out, {E, B});

        // Repeated word A, A, B.
        apply(1'b0, A, 1'b0, 1'b1, 1'b0);
        apply(1'b1, A, 1'b0, 1'b0, 1'b0);
        chk("rep_ack0", {255'b0, drng_ack}, 256'h1);
        apply(1'b1, A, 1'b0, 1'b0, 1'b0);
        chk("rep_ack1", {255'b0, drng_ack}, 256'h1);
        apply(1'b1, B, 1'b0, 1'b0, 1'b0);
`ifdef CR_KME_DRNG_HEALTH_CHECK_EN
        chk("rep_ack2", {255'b0, drng_ack}, 256'h1);
        apply(1'b0, B, 1'b0, 1'b0, 1'b0);
        chk("rep_kv",   {255'b0, key_valid},   256'h1);
        chk("rep_key",  key_out, {A, B});
        chk("rep_hf",   {255'b0, health_fail}, 256'h1);
        chk("rep_fc",   {248'b0, fail_cnt},    256'h1);
        apply(1'b0, B, 1'b0, 1'b1, 1'b0);
        apply(1'b0, B, 1'b0, 1'b0, 1'b0);
        chk("flush_hf", {255'b0, health_fail}, 256'h0);
        chk("flush_fc", {248'b0, fail_cnt},    256'h0);
        chk("flush_kv", {255'b0, key_valid},   256'h0);

        // Same word 300 times: one accept, then 299 rejects saturating at 255.
        for (int i = 0; i < 300; i++) begin
            apply(1'b1, E, 1'b0, 1'b0, 1'b0);
        end
        apply(1'b0, E, 1'b0, 1'b0, 1'b0);
        chk("sat_fc", {248'b0, fail_cnt},    256'd255);
        chk("sat_hf", {255'b0, health_fail}, 256'h1);
        chk("sat_kv", {255'b0, key_valid},   256'h0);
`else
        chk("rep_ack2_rdy", {255'b0, drng_ack}, 256'h0);
        apply(1'b0, B, 1'b0, 1'b0, 1'b0);
        chk("rep_kv",  {255'b0, key_valid},   256'h1);
        chk("rep_key", key_out, {A, A});
        chk("rep_hf",  {255'b0, health_fail}, 256'h0);
        chk("rep_fc",  {248'b0, fail_cnt},    256'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
